mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single unified 16-bit memory of the multicycle datapath. It shares the memory between the CPU datapath (instruction fetch, load and store traffic) and a loader/debug port used by the testbench to preload programs and inspect memory. Grants are round-robin, one transaction at a time, and each access takes a fixed memory latency. The block sits between the datapath's memory mux and the memory macro, and it raises a stall flag that the control FSM uses to hold its current state.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// State encodings, port identifiers and the wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

    // Wide enough for the full legal latency range of 1..7.
    localparam int LAT_W = 3;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin pick.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = PORT_CPU;
        if (req0 && req1) begin
            gnt_id = ~last;
        end else if (req1) begin
            gnt_id = PORT_LD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and access sequencer sharing the unified memory between the CPU
// datapath and the loader/debug port; one transaction in flight at a time.
//
//   state  | meaning
//   IDLE   | waiting for a request; arbitrates and latches the winner
//   ACCESS | read or write strobe is high for this single cycle
//   WAIT   | counting down the memory latency; captures read data at the end
//   RESP   | owner's ack is high for this single cycle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          nrst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [LAT_W-1:0] wait_cnt;
    logic             owner;
    logic             last_grant;
    logic             gnt_valid;
    logic             gnt_id;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req0      (cpu_req),
        .req1      (ld_req),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (gnt_id == PORT_LD) begin
            sel_we    = ld_we;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = WAIT;
            WAIT:    if (wait_cnt == LAT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and acks are registered one edge ahead so they line up with
    // the ACCESS and RESP cycles respectively.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wait_cnt   <= '0;
            owner      <= PORT_CPU;
            last_grant <= PORT_LD;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            cpu_ack    <= 1'b0;
            ld_ack     <= 1'b0;
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            ld_ack  <= 1'b0;
            busy    <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner      <= gnt_id;
                        last_grant <= gnt_id;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_re     <= ~sel_we;
                        mem_we     <= sel_we;
                    end
                end
                ACCESS: begin
                    wait_cnt <= LAT_W'(MEM_LAT);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - LAT_W'(1);
                    if (wait_cnt == LAT_W'(1)) begin
                        if (owner == PORT_LD) begin
                            ld_rdata <= mem_rdata;
                            ld_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: lane 0 runs MEM_LAT=1, lane 1 runs MEM_LAT=4, each
// with its own latency-accurate memory and a transaction-level reference.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       nrst = 2'b00;
    logic [1:0]       cpu_req = '0, cpu_we = '0, ld_req = '0, ld_we = '0;
    logic [1:0][15:0] cpu_addr = '0, cpu_wdata = '0, ld_addr = '0, ld_wdata = '0;
    logic [1:0]       cpu_ack, ld_ack, cpu_stall, mem_re, mem_we, busy;
    logic [1:0][15:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int lane, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %h, required %h at %0t", name, lane, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_lane
        localparam int LAT = (g == 0) ? 1 : 4;

        logic [15:0] rdata_drv = 16'hDEAD;
        logic [15:0] mem_arr [256];

        mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .nrst      (nrst[g]),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_stall (cpu_stall[g]),
            .ld_req    (ld_req[g]),
            .ld_we     (ld_we[g]),
            .ld_addr   (ld_addr[g]),
            .ld_wdata  (ld_wdata[g]),
            .ld_ack    (ld_ack[g]),
            .ld_rdata  (ld_rdata[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_re    (mem_re[g]),
            .mem_we    (mem_we[g]),
            .mem_rdata (rdata_drv),
            .busy      (busy[g])
        );

        // Memory: read data is valid only in the last latency cycle after
        // the strobe cycle, junk otherwise, so a mistimed capture shows up.
        int  k = 0;
        bit  act = 1'b0;
        initial begin
            for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
            mem_arr[8'h10] = 16'hBEEF;
            mem_arr[8'h20] = 16'hCAFE;
        end
        always @(negedge clk) begin
            if (mem_we[g]) mem_arr[mem_addr[g][7:0]] = mem_wdata[g];
            if (mem_re[g] || mem_we[g]) begin
                act = 1'b1;
                k   = 0;
            end else if (act) begin
                k++;
            end
            rdata_drv = (act && k == LAT) ? mem_arr[mem_addr[g][7:0]] : 16'hDEAD;
        end

        // Reference: t counts cycles since the granting edge (0 = idle).
        int          t = 0;
        logic        m_owner = 1'b0, m_last = 1'b1, m_we = 1'b0;
        logic [15:0] m_addr = '0, m_wdata = '0;
        logic [15:0] m_rd [2] = '{16'h0, 16'h0};
        bit          m_known [2] = '{1'b1, 1'b1};

        always @(posedge clk or negedge nrst[g]) begin
            if (!nrst[g]) begin
                t = 0; m_owner = 1'b0; m_last = 1'b1; m_we = 1'b0;
                m_addr = '0; m_wdata = '0;
                m_rd[0] = '0; m_rd[1] = '0; m_known[0] = 1'b1; m_known[1] = 1'b1;
            end else if (t == 0) begin
                if (cpu_req[g] || ld_req[g]) begin
                    m_owner = (cpu_req[g] && ld_req[g]) ? ~m_last : ld_req[g];
                    m_last  = m_owner;
                    m_we    = m_owner ? ld_we[g]    : cpu_we[g];
                    m_addr  = m_owner ? ld_addr[g]  : cpu_addr[g];
                    m_wdata = m_owner ? ld_wdata[g] : cpu_wdata[g];
                    t = 1;
                end
            end else if (t == LAT + 2) begin
                t = 0;
            end else begin
                t++;
                if (t == LAT + 2) begin
                    m_known[m_owner] = !m_we;
                    if (!m_we) m_rd[m_owner] = mem_arr[m_addr[7:0]];
                end
            end
        end

        always @(negedge clk) begin
            logic e_cack;
            e_cack = (t == LAT + 2) && (m_owner == 1'b0);
            chk("busy",      g, 16'(busy[g]),      16'(t != 0));
            chk("mem_re",    g, 16'(mem_re[g]),    16'(t == 1 && !m_we));
            chk("mem_we",    g, 16'(mem_we[g]),    16'(t == 1 && m_we));
            chk("cpu_ack",   g, 16'(cpu_ack[g]),   16'(e_cack));
            chk("ld_ack",    g, 16'(ld_ack[g]),    16'((t == LAT + 2) && m_owner));
            chk("cpu_stall", g, 16'(cpu_stall[g]), 16'(cpu_req[g] && !e_cack));
            chk("mem_addr",  g, mem_addr[g],  m_addr);
            chk("mem_wdata", g, mem_wdata[g], m_wdata);
            if (m_known[0]) chk("cpu_rdata", g, cpu_rdata[g], m_rd[0]);
            if (m_known[1]) chk("ld_rdata",  g, ld_rdata[g],  m_rd[1]);
        end
    end

    // Per-cycle logs of one directed sequence; bit c is cycle c after E0.
    logic [31:0] re_log, we_log, cack_log, lack_log, stall_log;
    logic [15:0] crd_last, lrd_last, wa, wd;

    task automatic run_seq(input int g, input int ncyc, input int drop_c);
        re_log = '0; we_log = '0; cack_log = '0; lack_log = '0; stall_log = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            re_log[c]    = mem_re[g];
            we_log[c]    = mem_we[g];
            cack_log[c]  = cpu_ack[g];
            lack_log[c]  = ld_ack[g];
            stall_log[c] = cpu_stall[g];
            if (cpu_ack[g]) crd_last = cpu_rdata[g];
            if (ld_ack[g])  lrd_last = ld_rdata[g];
            if (mem_we[g]) begin
                wa = mem_addr[g];
                wd = mem_wdata[g];
            end
            @(posedge clk);
            #1;
            if (c == drop_c) begin
                cpu_req[g] = 1'b0;
                ld_req[g]  = 1'b0;
            end
        end
    endtask

    task automatic pulse_reset(input int g);
        @(negedge clk);
        #2 nrst[g] = 1'b0;
        @(negedge clk);
        #2 nrst[g] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy",  g, 16'(busy[g]), 16'h0);
            chk("rst_strb",  g, 16'({mem_re[g], mem_we[g]}), 16'h0);
            chk("rst_acks",  g, 16'({cpu_ack[g], ld_ack[g]}), 16'h0);
            chk("rst_addr",  g, mem_addr[g], 16'h0);
            chk("rst_rdata", g, cpu_rdata[g] | ld_rdata[g], 16'h0);
        end
        @(negedge clk);
        #2 nrst = 2'b11;
        @(posedge clk);
        #1;

        // Single CPU read, latency 1.
        cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0010; cpu_req[0] = 1'b1;
        run_seq(0, 6, 3);
        chk("rd_re_cycles",    0, re_log[15:0],    16'h0002);
        chk("rd_ack_cycles",   0, cack_log[15:0],  16'h0008);
        chk("rd_stall_cycles", 0, stall_log[15:0], 16'h0007);
        chk("rd_data",         0, crd_last,        16'hBEEF);

        // Loader write.
        ld_we[0] = 1'b1; ld_addr[0] = 16'h0004; ld_wdata[0] = 16'h1234; ld_req[0] = 1'b1;
        run_seq(0, 6, 3);
        chk("wr_we_cycles",  0, we_log[15:0],   16'h0002);
        chk("wr_re_cycles",  0, re_log[15:0],   16'h0000);
        chk("wr_ack_cycles", 0, lack_log[15:0], 16'h0008);
        chk("wr_addr",       0, wa, 16'h0004);
        chk("wr_data",       0, wd, 16'h1234);
        chk("wr_mem",        0, gen_lane[0].mem_arr[4], 16'h1234);

        // Tie from reset, both held: CPU, LD, CPU, LD.
        pulse_reset(0);
        ld_we[0] = 1'b0; ld_addr[0] = 16'h0004;
        cpu_req[0] = 1'b1; ld_req[0] = 1'b1;
        run_seq(0, 18, 15);
        chk("tie_cpu_acks", 0, cack_log[15:0], 16'h0808);
        chk("tie_ld_acks",  0, lack_log[15:0], 16'h8080);
        chk("tie_re",       0, re_log[15:0],   16'h2222);
        chk("tie_cpu_data", 0, crd_last, 16'hBEEF);
        chk("tie_ld_data",  0, lrd_last, 16'h1234);

        // Reset dropped during WAIT, then a fresh request.
        cpu_req[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 nrst[0] = 1'b0;
        #1;
        chk("midrst_busy", 0, 16'(busy[0]), 16'h0);
        chk("midrst_strb", 0, 16'({mem_re[0], mem_we[0]}), 16'h0);
        chk("midrst_ack",  0, 16'({cpu_ack[0], ld_ack[0]}), 16'h0);
        chk("midrst_addr", 0, mem_addr[0], 16'h0);
        cpu_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 nrst[0] = 1'b1;
        @(posedge clk);
        #1;
        cpu_req[0] = 1'b1;
        run_seq(0, 6, 3);
        chk("postrst_re",   0, re_log[15:0],   16'h0002);
        chk("postrst_ack",  0, cack_log[15:0], 16'h0008);
        chk("postrst_data", 0, crd_last, 16'hBEEF);

        // Latency 4, back-to-back CPU reads.
        cpu_we[1] = 1'b0; cpu_addr[1] = 16'h0020; cpu_req[1] = 1'b1;
        run_seq(1, 16, 13);
        chk("lat4_re",   1, re_log[15:0],   16'h0102);
        chk("lat4_ack",  1, cack_log[15:0], 16'h2040);
        chk("lat4_data", 1, crd_last, 16'hCAFE);

        // CPU request held through its own acks.
        cpu_req[0] = 1'b1;
        run_seq(0, 14, 11);
        chk("held_re",  0, re_log[15:0],   16'h0222);
        chk("held_ack", 0, cack_log[15:0], 16'h0888);
        chk("held_ld",  0, lack_log[15:0], 16'h0000);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
